// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared register-index and load-queue entry types
package hazard_pkg;
  typedef logic [4:0] reg_idx_t;
  localparam reg_idx_t REG_ZERO = '0;
  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
  } lq_entry_t;
endpackage

// File: rtl/load_dest_queue.sv
// rtl/load_dest_queue.sv - circular FIFO of in-flight load destinations with per-entry compare vectors
module load_dest_queue import hazard_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  reg_idx_t         push_rd,
  input  logic             pop,
  input  reg_idx_t         cmp_a,
  input  reg_idx_t         cmp_b,
  output logic [DEPTH-1:0] match_a,
  output logic [DEPTH-1:0] match_b,
  output logic [DEPTH-1:0] head_sel,
  output reg_idx_t         head_rd,
  output logic [CW-1:0]    count
);
  lq_entry_t     entries [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  // On a full-queue push+pop head==tail; the push is written last so it wins the slot.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      if (pop) begin
        entries[head].valid <= 1'b0;
        head                <= head + PW'(1);
      end
      if (push) begin
        entries[tail] <= '{valid: 1'b1, rd: push_rd};
        tail          <= tail + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    match_a  = '0;
    match_b  = '0;
    head_sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_a[i] = entries[i].valid && (entries[i].rd == cmp_a);
      match_b[i] = entries[i].valid && (entries[i].rd == cmp_b);
    end
    head_sel[head] = 1'b1;
  end

  assign head_rd = entries[head].rd;
endmodule

// File: rtl/load_hazard_scoreboard.sv
// rtl/load_hazard_scoreboard.sv - decode-stage load-use stall logic; LOAD_HAZARD_PERF_EN adds stall/load counters
module load_hazard_scoreboard import hazard_pkg::*; #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int LOAD_Q_DEPTH  = 4
) (
  input  logic                     iClk,
  input  logic                     iRstN,
  input  logic [ADDRESS_WIDTH-1:0] iRs1,
  input  logic [ADDRESS_WIDTH-1:0] iRs2,
  input  logic                     iRs1Used,
  input  logic                     iRs2Used,
  input  logic                     iIssueValid,
  input  logic                     iIssueIsLoad,
  input  logic [ADDRESS_WIDTH-1:0] iIssueRd,
  input  logic                     iWbLoadEn,
  input  logic [ADDRESS_WIDTH-1:0] iWbAddr,
  input  logic                     iFlush,
  output logic                     oStall,
  output logic [ADDRESS_WIDTH-1:0] oQCount,
  output logic                     oProtoErr
`ifdef LOAD_HAZARD_PERF_EN
  ,
  output logic [31:0]              oStallCycles,
  output logic [31:0]              oLoadCount
`endif
);
  localparam int CW = $clog2(LOAD_Q_DEPTH) + 1;

  reg_idx_t                rs1, rs2, issue_rd, wb_addr, head_rd;
  logic [LOAD_Q_DEPTH-1:0] match1, match2, head_sel, bypass_mask;
  logic [CW-1:0]           count;
  logic                    hazard1, hazard2, structural, push, pop, empty, full;

  assign rs1      = reg_idx_t'(iRs1);
  assign rs2      = reg_idx_t'(iRs2);
  assign issue_rd = reg_idx_t'(iIssueRd);
  assign wb_addr  = reg_idx_t'(iWbAddr);

  load_dest_queue #(.DEPTH(LOAD_Q_DEPTH)) u_queue (
    .clk      (iClk),
    .rstn     (iRstN),
    .push     (push),
    .push_rd  (issue_rd),
    .pop      (pop),
    .cmp_a    (rs1),
    .cmp_b    (rs2),
    .match_a  (match1),
    .match_b  (match2),
    .head_sel (head_sel),
    .head_rd  (head_rd),
    .count    (count)
  );

  assign empty = (count == '0);
  assign full  = (count == CW'(LOAD_Q_DEPTH));

  // The writing-back load is visible to decode through the regfile the same cycle.
  assign bypass_mask = iWbLoadEn ? ~head_sel : '1;
  assign hazard1     = iRs1Used && (rs1 != REG_ZERO) && |(match1 & bypass_mask);
  assign hazard2     = iRs2Used && (rs2 != REG_ZERO) && |(match2 & bypass_mask);
  assign structural  = full && !iWbLoadEn && iIssueIsLoad;
  assign oStall      = iRstN && !iFlush && (hazard1 || hazard2 || structural);

  assign push    = iIssueValid && iIssueIsLoad && (issue_rd != REG_ZERO) && !oStall && !iFlush;
  assign pop     = iWbLoadEn && !empty;
  assign oQCount = ADDRESS_WIDTH'(count);

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      oProtoErr <= 1'b0;
    end else if (iWbLoadEn && (empty || (wb_addr != head_rd))) begin
      oProtoErr <= 1'b1;
    end
  end

`ifdef LOAD_HAZARD_PERF_EN
  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      oStallCycles <= '0;
      oLoadCount   <= '0;
    end else begin
      oStallCycles <= oStallCycles + 32'(oStall);
      oLoadCount   <= oLoadCount + 32'(push);
    end
  end
`endif
endmodule
